// File: rtl/counter_sched_pkg.sv
// Shared constants and state encoding for the counter run scheduler.
// The state enum is built on the encoding localparams so both views stay in sync.
package counter_sched_pkg;

    localparam int DEF_LEN_W   = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int CNT_W       = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        RUN   = ST_RUN,
        STOP  = ST_STOP,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scan starts at ptr and the first set request wins.
// The owner of ptr decides when the pointer advances.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    int               pos;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        // NOTE: blocking assignments here so found/pos are seen updated within the same pass of the loop.
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/counter_run_scheduler.sv
// Time-shares one start/stop counter among NUM_REQ requesters: round-robin grant,
// start/stop pulses len cycles apart, then returns the captured count with a done pulse.
module counter_run_scheduler
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*LEN_W-1:0] len_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic [CNT_W-1:0]         result_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic                     cnt_start_o,
    output logic                     cnt_stop_o,
    input  logic [CNT_W-1:0]         cnt_value_i,
    input  logic                     cnt_valid_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   run_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_next;
    logic [CNT_W-1:0]   result_q;
    logic               err_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [LEN_W-1:0]   arb_len;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_i),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_len  = len_i[arb_idx*LEN_W +: LEN_W];
    assign tmo_next = tmo_cnt + TMO_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            len_q    <= '0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        idx_q   <= arb_idx;
                        grant_q <= arb_grant;
                        len_q   <= (arb_len == '0) ? LEN_W'(1) : arb_len;
                        state   <= START;
                    end
                end
                START: begin
                    run_cnt <= len_q;
                    state   <= (len_q == LEN_W'(1)) ? STOP : RUN;
                end
                // run_cnt counts down from len to 2, placing STOP exactly len cycles after START.
                RUN: begin
                    if (run_cnt == LEN_W'(2)) begin
                        state <= STOP;
                    end else begin
                        run_cnt <= run_cnt - LEN_W'(1);
                    end
                end
                STOP: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (cnt_valid_i) begin
                        result_q <= cnt_value_i;
                        err_q    <= 1'b0;
                        state    <= DONE;
                    end else if (tmo_next == TMO_W'(TIMEOUT - 1)) begin
                        // Give up so DONE lands TIMEOUT cycles after the stop pulse.
                        tmo_cnt  <= tmo_next;
                        result_q <= '0;
                        err_q    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                DONE: begin
                    rr_ptr <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state != IDLE);
    assign cnt_start_o = (state == START);
    assign cnt_stop_o  = (state == STOP);
    assign grant_o     = busy_o ? grant_q : '0;
    assign done_o      = (state == DONE) ? grant_q : '0;
    assign err_o       = (state == DONE) && err_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_counter_run_scheduler.sv
// Directed bench for counter_run_scheduler with a behavioural counter unit and a
// scoreboard of expected completions popped on each done pulse.
module tb_counter_run_scheduler;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] len;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [7:0]               result;
    logic                     err;
    logic                     busy;
    logic                     cnt_start;
    logic                     cnt_stop;
    logic [7:0]               cnt_value;
    logic                     cnt_valid;

    always #5 clk = ~clk;

    counter_run_scheduler #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_i       (req),
        .len_i       (len),
        .grant_o     (grant),
        .done_o      (done),
        .result_o    (result),
        .err_o       (err),
        .busy_o      (busy),
        .cnt_start_o (cnt_start),
        .cnt_stop_o  (cnt_stop),
        .cnt_value_i (cnt_value),
        .cnt_valid_i (cnt_valid)
    );

    typedef struct {
        logic [3:0] done;
        logic [7:0] result;
        logic       err;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Counter unit: counts cycles from start to stop, reports one cycle after stop.
    logic       model_mute = 1'b0;
    logic       m_run;
    logic [7:0] m_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_run     <= 1'b0;
            m_cnt     <= 8'd0;
            cnt_valid <= 1'b0;
            cnt_value <= 8'd0;
        end else begin
            cnt_valid <= 1'b0;
            if (cnt_start) begin
                m_run <= 1'b1;
                m_cnt <= 8'd0;
            end else if (cnt_stop && m_run) begin
                m_run     <= 1'b0;
                cnt_valid <= !model_mute;
                cnt_value <= m_cnt + 8'd1;
            end else if (m_run) begin
                m_cnt <= m_cnt + 8'd1;
            end
        end
    end

    // Cycle-stamped protocol monitor, sampling the values of the cycle that is ending.
    int   cyc = 0;
    int   start_cyc = 0;
    int   stop_cyc = 0;
    int   done_cyc = 0;
    int   overlap = 0;
    int   multi_pulse = 0;
    int   grant2_seen = 0;
    logic prev_start = 1'b0;
    logic prev_stop = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (cnt_start) start_cyc = cyc;
        if (cnt_stop) stop_cyc = cyc;
        if (done != '0) done_cyc = cyc;
        if (cnt_start && cnt_stop) overlap++;
        if ((cnt_start && prev_start) || (cnt_stop && prev_stop)) multi_pulse++;
        if (grant[2]) grant2_seen++;
        prev_start = cnt_start;
        prev_stop  = cnt_stop;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (cnt_start !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":start_seen"}, 32'(cnt_start), 32'd1);
    endtask

    // Waits for the next done pulse and compares it with the oldest expectation.
    task automatic serve(input string tag, input logic [3:0] clear_mask);
        exp_t e;
        int   n = 0;
        while (done === '0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, ":unexpected_done"}, 32'(done), 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, ":done"}, 32'(done), 32'(e.done));
        if (done === '0) return;
        check({tag, ":grant"}, 32'(grant), 32'(e.done));
        check({tag, ":result"}, 32'(result), 32'(e.result));
        check({tag, ":err"}, 32'(err), 32'(e.err));
        check({tag, ":start_to_stop"}, 32'(stop_cyc - start_cyc), 32'(e.gap));
        req = req & ~clear_mask;
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[3] = '{0, 1, 255};
        int prev_done;

        rstn = 1'b0;
        req  = '0;
        len  = '0;
        repeat (3) @(negedge clk);
        check("rst:grant", 32'(grant), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:result", 32'(result), 32'd0);
        check("rst:err", 32'(err), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:start", 32'(cnt_start), 32'd0);
        check("rst:stop", 32'(cnt_stop), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Contention from rr_ptr=0: 0,1,3 then wrap to 0, never 2.
        len = {8'd2, 8'd2, 8'd2, 8'd2};
        req = 4'b1011;
        sb.push_back('{4'b0001, 8'd2, 1'b0, 2});
        sb.push_back('{4'b0010, 8'd2, 1'b0, 2});
        sb.push_back('{4'b1000, 8'd2, 1'b0, 2});
        sb.push_back('{4'b0001, 8'd2, 1'b0, 2});
        prev_done = 0;
        for (int k = 0; k < 4; k++) begin
            serve($sformatf("rr%0d", k), (k == 3) ? 4'hF : 4'h0);
            if (k > 0) check($sformatf("rr%0d:turnaround", k), 32'(start_cyc - prev_done), 32'd2);
            prev_done = done_cyc;
        end
        check("rr:no_grant2", 32'(grant2_seen), 32'd0);

        // Single requester, len 5.
        len = {8'd0, 8'd0, 8'd0, 8'd5};
        req = 4'b0001;
        sb.push_back('{4'b0001, 8'd5, 1'b0, 5});
        serve("single", 4'b0001);

        // Boundary lengths: 0 behaves as 1, 255 is a full-range run.
        for (int i = 0; i < 3; i++) begin
            len[7:0] = 8'(lens[i]);
            req      = 4'b0001;
            sb.push_back('{4'b0001, 8'((lens[i] == 0) ? 1 : lens[i]), 1'b0, (lens[i] == 0) ? 1 : lens[i]});
            serve($sformatf("len%0d", lens[i]), 4'b0001);
        end

        // Requester 1 drops its request mid-run.
        len = {8'd0, 8'd0, 8'd6, 8'd0};
        req = 4'b0010;
        sb.push_back('{4'b0010, 8'd6, 1'b0, 6});
        wait_start("drop");
        repeat (2) @(negedge clk);
        req = 4'b0000;
        serve("drop", 4'b0000);
        repeat (5) @(negedge clk);
        check("drop:result_held", 32'(result), 32'd6);
        check("drop:idle_after", 32'(busy), 32'd0);

        // Counter never answers: timeout path.
        model_mute = 1'b1;
        len = {8'd0, 8'd0, 8'd0, 8'd3};
        req = 4'b0001;
        sb.push_back('{4'b0001, 8'd0, 1'b1, 3});
        serve("timeout", 4'b0001);
        check("timeout:stop_to_done", 32'(done_cyc - stop_cyc), 32'(TIMEOUT));
        model_mute = 1'b0;

        len = {8'd0, 8'd4, 8'd0, 8'd0};
        req = 4'b0100;
        sb.push_back('{4'b0100, 8'd4, 1'b0, 4});
        serve("recover", 4'b0100);

        // Reset at T+3 of a len=10 run on requester 3 (rr_ptr is 3 here).
        len = {8'd10, 8'd0, 8'd0, 8'd0};
        req = 4'b1000;
        wait_start("rstrun");
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rstrun:grant", 32'(grant), 32'd0);
        check("rstrun:start", 32'(cnt_start), 32'd0);
        check("rstrun:stop", 32'(cnt_stop), 32'd0);
        check("rstrun:done", 32'(done), 32'd0);
        check("rstrun:busy", 32'(busy), 32'd0);
        check("rstrun:result", 32'(result), 32'd0);
        check("rstrun:err", 32'(err), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
        len = {8'd3, 8'd3, 8'd0, 8'd0};
        req = 4'b1100;
        sb.push_back('{4'b0100, 8'd3, 1'b0, 3});
        sb.push_back('{4'b1000, 8'd3, 1'b0, 3});
        serve("post_rst_a", 4'b0100);
        serve("post_rst_b", 4'b1000);

        check("proto:start_stop_overlap", 32'(overlap), 32'd0);
        check("proto:multi_cycle_pulse", 32'(multi_pulse), 32'd0);
        check("sb:leftover", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_run_scheduler.md
Name: counter_run_scheduler

Overview:
Shares one start/stop-controlled 8-bit counter unit among NUM_REQ requesters. Each requester asks for a timed counting run of a programmed length. The scheduler grants requesters round-robin and pulses the counter's start and stop inputs that many cycles apart. It then captures the counter's reported value and returns it to the winning requester with a done pulse. It sits between requester logic and the counter's start_i/stop_i/counter_o/valid_o interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 8, width of each requested run length
TIMEOUT, 16, max cycles to wait for cnt_valid_i after stop before flagging an error

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  level request per requester; held until its done_o
len_i  in  NUM_REQ*LEN_W  run length per requester, slice k = len_i[k*LEN_W +: LEN_W]
grant_o  out  NUM_REQ  one-hot, winner held from START through DONE
done_o  out  NUM_REQ  one-cycle completion pulse to the winner
result_o  out  8  captured counter value; valid on done_o, held until the next DONE
err_o  out  1  high with done_o when the run timed out
busy_o  out  1  high whenever state != IDLE
cnt_start_o  out  1  one-cycle start pulse to the counter
cnt_stop_o  out  1  one-cycle stop pulse to the counter
cnt_value_i  in  8  counter value from the counter unit
cnt_valid_i  in  1  counter value-valid from the counter unit

Behaviour:
- Reset (async, rstn_i=0): state=IDLE, rr_ptr=0, and all outputs are 0, including result_o. Reset mid-run drops cnt_start_o/cnt_stop_o and grant_o immediately. No done_o is issued for the aborted run.
- States: IDLE, START, RUN, STOP, WAIT, DONE. All outputs are registered or decoded from state.
- IDLE: if |req_i, pick the winner round-robin:
  - Search starts at rr_ptr; the first set bit wins.
  - Latch idx and len (len=0 is treated as 1).
  - Go to START. Otherwise stay in IDLE.
- START (cycle T): cnt_start_o=1, grant_o[idx]=1, run_cnt=len.
  - Next state is STOP if len==1, else RUN.
- RUN: decrement run_cnt each cycle. When run_cnt==2, the next state is STOP.
  - Net effect: cnt_stop_o fires at exactly T+len.
- STOP: cnt_stop_o=1 for one cycle, tmo_cnt=0, then go to WAIT.
- WAIT:
  - If cnt_valid_i=1, capture cnt_value_i into result_o, clear err, go to DONE.
  - Else increment tmo_cnt. When tmo_cnt reaches TIMEOUT-1, set result_o=0 and err=1, then go to DONE.
- DONE: done_o[idx]=1 and err_o=err for one cycle. Set rr_ptr=(idx+1) mod NUM_REQ, then return to IDLE.
  - Minimum turnaround: a new START no earlier than 2 cycles after DONE (IDLE, then START).
- req_i deasserted mid-run: the run still completes and done_o still pulses.
- len_i and req_i are sampled only in IDLE; changes during a run are ignored.
- Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ-1 other runs.
- Width rules:
  - run_cnt and tmo_cnt saturate-free. run_cnt is LEN_W bits; tmo_cnt is $clog2(TIMEOUT+1) bits.
  - len=2^LEN_W-1 is legal (255 cycles by default).
- cnt_start_o and cnt_stop_o are never high in the same cycle. Each is high for exactly one cycle per run.

Decomposition:
- Shared package counter_sched_pkg holds:
  - state encoding localparams (IDLE..DONE)
  - default LEN_W and TIMEOUT constants
  - the 8-bit counter data width constant
- One sub-module, rr_arbiter: NUM_REQ-wide, inputs req and ptr, outputs a one-hot grant and a binary index, purely combinational. The FSM owns rr_ptr.

Test Plan:
- Single requester: req_i=4'b0001, len0=5, counter model returns value 5 with valid 1 cycle after stop.
  -> cnt_start_o at T, cnt_stop_o at T+5, done_o=4'b0001, result_o=5, err_o=0.
- Contention: req_i=4'b1011 held, all len=2.
  -> Grant order 0,1,3,0. rr_ptr wraps correctly; no grant to requester 2.
- Boundary lengths: len=0, then len=1.
  -> Both give cnt_stop_o exactly 1 cycle after cnt_start_o. len=255 gives 255 cycles.
- Timeout: counter model never asserts cnt_valid_i, TIMEOUT=16.
  -> done_o 16 cycles after the stop pulse, err_o=1, result_o=0. The next request is served normally.
- Reset mid-RUN: rstn_i=0 at T+3 of a len=10 run.
  -> All outputs 0 immediately, no done_o. After release, req_i=4'b0100 is granted first-by-scan from rr_ptr=0.
- Request drop: requester 1 deasserts req_i during RUN.
  -> Run completes, done_o[1] pulses, result_o is held until the next DONE.
